imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Boot-time writer for instruction memory: receives a byte stream from a host, packs
//  big-endian 32-bit words, writes them into IMem via its write port, holds the CPU in
//  reset while loading. Sits between host link and IMem write side / PC reset input.
// PARAMETERS
//  ADDR_WIDTH  8        word-address bits; IMem depth = 2**ADDR_WIDTH words
//  BASE_ADDR   32'h0    byte address of the first loaded word
// PORTS
//  CLK        in   1   system clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  start      in   1   1-cycle pulse: begin a load (accepted in IDLE, DONE, ERR only)
//  in_valid   in   1   host byte valid
//  in_data    in   8   host byte
//  in_ready   out  1   loader accepts byte; transfer when in_valid && in_ready
//  mem_we     out  1   IMem write strobe, one cycle per word
//  mem_addr   out  32  IMem byte address, word aligned
//  mem_wdata  out  32  IMem write data
//  cpu_rst_n  out  1   CPU reset, low while not in DONE
//  busy/done/err out 1 status: loading / program valid / load aborted
// BEHAVIOUR
//  Reset: state IDLE; in_ready, mem_we, busy, done, err, cpu_rst_n = 0;
//   mem_addr, mem_wdata, byte counter, word index, length = 0. Partial word discarded.
//  States: IDLE -> LEN -> LOAD [-> CSUM] -> DONE; any -> ERR on fault.
//  in_ready = 1 only in LEN, LOAD, CSUM; busy = same.
//  Packing: 2-bit byte count; word <= {word[23:0], in_data}; first byte = MSB.
//   4th accepted byte completes a word; count wraps to 0.
//  LEN: completed word = N. N == 0 or N > 2**ADDR_WIDTH -> ERR; else idx=0, -> LOAD.
//  LOAD: cycle after 4th byte: mem_we=1 for exactly one cycle,
//   mem_addr = BASE_ADDR + 4*idx (mod 2^32), mem_wdata = word; idx++.
//   When idx reaches N: -> DONE (-> CSUM if CHECKSUM_EN). Last mem_we and state
//   change occur in the same cycle. Back-to-back bytes sustain 1 word / 4 cycles.
//  DONE: done=1, cpu_rst_n=1 (rises the cycle after the last mem_we).
//  ERR: err=1, cpu_rst_n=0, in_ready=0.
//  start in IDLE/DONE/ERR: next cycle -> LEN; done, err, cpu_rst_n cleared, counters 0.
//  start in LEN/LOAD/CSUM: ignored. in_valid while in_ready=0: byte not consumed.
//  Start and in_valid same cycle in IDLE: byte not consumed (in_ready still 0).
// CONFIGURATION
//  CHECKSUM_EN defined: 32-bit running sum (mod 2^32) of the N data words; after last
//   word enter CSUM, receive one more word; equal -> DONE, else -> ERR. No mem_we in CSUM.
//  Not defined: no CSUM state, no sum register; last data word -> DONE directly.
// STRUCTURE
//  imem_loader_pkg: state enum typedef (IDLE, LEN, LOAD, CSUM, DONE, ERR),
//   WORD_BYTES = 4, BYTE_W = 8.
//  Sub-module byte_packer: byte count + shift register, outputs word and word_valid
//   pulse; imem_loader holds FSM, index, length, checksum, IMem drive.
// TESTING
//  1 Reset: rst_n=0 mid-LOAD -> all outputs 0 immediately, state IDLE, cpu_rst_n=0.
//  2 start; bytes 00 00 00 02, 12 34 56 78, 9A BC DE F0 -> mem_we at addr 0x0 data
//    0x12345678, addr 0x4 data 0x9ABCDEF0; done=1, cpu_rst_n=1 next cycle.
//  3 Length 0x00000000 -> err=1, no mem_we; length 0x00000101 (ADDR_WIDTH=8) -> err=1.
//  4 Random in_valid gaps, BASE_ADDR=0x100, N=3 -> addrs 0x100/0x104/0x108, data intact.
//  5 start during LOAD -> ignored; start in DONE -> cpu_rst_n=0, reload succeeds.
//  6 CHECKSUM_EN, N=2 words 1,2: csum 0x00000003 -> DONE; csum 0x4 -> ERR, cpu_rst_n=0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_loader_pkg : shared types and constants for the IMem boot loader |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package imem_loader_pkg;

  localparam int WORD_BYTES = 4;
  localparam int BYTE_W     = 8;
  localparam int WORD_W     = WORD_BYTES * BYTE_W;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    LOAD = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

  // States in which the loader is consuming host bytes
  function automatic logic is_active(input state_t s);
    return (s == LEN) || (s == LOAD) || (s == CSUM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/imem_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_loader_if : host byte stream plus IMem write port               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface imem_loader_if;
  import imem_loader_pkg::*;

  logic              in_valid;
  logic [BYTE_W-1:0] in_data;
  logic              in_ready;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [WORD_W-1:0] mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_loader_byte_packer : packs bytes MSB-first into 32-bit words    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic [WORD_W-1:0] word,
  output logic              word_valid
);

  logic [1:0]        r_cnt;
  logic [WORD_W-1:0] r_shift;

  // Word and pulse are presented in the same cycle as the completing byte
  assign word       = {r_shift[WORD_W-BYTE_W-1:0], byte_data};
  assign word_valid = byte_valid && (r_cnt == 2'(WORD_BYTES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= 2'd0;
      r_shift <= '0;
    end else if (clear) begin
      r_cnt   <= 2'd0;
      r_shift <= '0;
    end else if (byte_valid) begin
      r_cnt   <= r_cnt + 2'd1;
      r_shift <= word;
    end
  end

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_loader : boot-time IMem writer, holds CPU in reset while loading |
// | Optional macro CHECKSUM_EN adds a trailing 32-bit sum word check.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          cpu_rst_n,
  output logic          busy,
  output logic          done,
  output logic          err
);

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_WIDTH:0] r_idx;
  logic [ADDR_WIDTH:0] r_len;
  logic                r_mem_we;
  logic [31:0]         r_mem_addr;
  logic [WORD_W-1:0]   r_mem_wdata;
`ifdef CHECKSUM_EN
  logic [WORD_W-1:0]   r_sum;
`endif

  logic                w_active;
  logic                w_start_ok;
  logic                w_accept;
  logic [WORD_W-1:0]   w_word;
  logic                w_word_valid;
  logic                w_len_bad;
  logic                w_last;

  assign w_active   = is_active(r_state);
  assign w_start_ok = start && !w_active;
  assign w_accept   = bus.in_valid && w_active;

  // Length must be 1 .. 2**ADDR_WIDTH words
  assign w_len_bad = (w_word == '0) || ({1'b0, w_word} > (33'd1 << ADDR_WIDTH));
  assign w_last    = ((r_idx + (ADDR_WIDTH+1)'(1)) == r_len);

  assign bus.in_ready  = w_active;
  assign busy          = w_active;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;

  imem_loader_byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (w_start_ok),
    .byte_valid (w_accept),
    .byte_data  (bus.in_data),
    .word       (w_word),
    .word_valid (w_word_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, DONE, ERR: if (start) w_state_next = LEN;
      LEN:             if (w_word_valid) w_state_next = w_len_bad ? ERR : LOAD;
      LOAD: begin
        if (w_word_valid && w_last) begin
`ifdef CHECKSUM_EN
          w_state_next = CSUM;
`else
          w_state_next = DONE;
`endif
        end
      end
`ifdef CHECKSUM_EN
      CSUM:            if (w_word_valid) w_state_next = (w_word == r_sum) ? DONE : ERR;
`endif
      default:         w_state_next = IDLE;
    endcase
  end

  // Status outputs follow the state register by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_len       <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      cpu_rst_n   <= 1'b0;
`ifdef CHECKSUM_EN
      r_sum       <= '0;
`endif
    end else begin
      r_mem_we  <= 1'b0;
      done      <= (r_state == DONE) && !w_start_ok;
      cpu_rst_n <= (r_state == DONE) && !w_start_ok;
      err       <= (r_state == ERR)  && !w_start_ok;
      if (w_start_ok) begin
        r_idx <= '0;
        r_len <= '0;
`ifdef CHECKSUM_EN
        r_sum <= '0;
`endif
      end
      if (r_state == LEN && w_word_valid && !w_len_bad) begin
        r_len <= w_word[ADDR_WIDTH:0];
        r_idx <= '0;
      end
      if (r_state == LOAD && w_word_valid) begin
        r_mem_we    <= 1'b1;
        r_mem_addr  <= BASE_ADDR + 32'({r_idx, 2'b00});
        r_mem_wdata <= w_word;
        r_idx       <= r_idx + (ADDR_WIDTH+1)'(1);
`ifdef CHECKSUM_EN
        r_sum       <= r_sum + w_word;
`endif
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_imem_loader : directed self-checking bench for imem_loader         |
// | Exercises the CHECKSUM_EN path when that macro is defined.            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tb_start;
  logic       tb_valid;
  logic [7:0] tb_data;
  logic       sel;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int wr_n   = 0;
  logic [31:0] wr_addr [0:63];
  logic [31:0] wr_data [0:63];
  int          wr_cyc  [0:63];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  imem_loader_if bus_a ();
  imem_loader_if bus_b ();

  logic start_a, start_b;
  logic cpu_rst_n_a, busy_a, done_a, err_a;
  logic cpu_rst_n_b, busy_b, done_b, err_b;

  assign start_a        = tb_start & ~sel;
  assign start_b        = tb_start &  sel;
  assign bus_a.in_valid = tb_valid & ~sel;
  assign bus_b.in_valid = tb_valid &  sel;
  assign bus_a.in_data  = tb_data;
  assign bus_b.in_data  = tb_data;

  imem_loader #(.ADDR_WIDTH(8), .BASE_ADDR(32'h0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .bus(bus_a),
    .cpu_rst_n(cpu_rst_n_a), .busy(busy_a), .done(done_a), .err(err_a)
  );

  imem_loader #(.ADDR_WIDTH(8), .BASE_ADDR(32'h100)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .bus(bus_b),
    .cpu_rst_n(cpu_rst_n_b), .busy(busy_b), .done(done_b), .err(err_b)
  );

  logic        in_ready, mem_we, busy, done, err, cpu_rst_n;
  logic [31:0] mem_addr, mem_wdata;
  assign in_ready  = sel ? bus_b.in_ready  : bus_a.in_ready;
  assign mem_we    = sel ? bus_b.mem_we    : bus_a.mem_we;
  assign mem_addr  = sel ? bus_b.mem_addr  : bus_a.mem_addr;
  assign mem_wdata = sel ? bus_b.mem_wdata : bus_a.mem_wdata;
  assign busy      = sel ? busy_b      : busy_a;
  assign done      = sel ? done_b      : done_a;
  assign err       = sel ? err_b       : err_a;
  assign cpu_rst_n = sel ? cpu_rst_n_b : cpu_rst_n_a;

  always @(negedge clk) begin
    if (bus_a.mem_we === 1'b1 && wr_n < 64) begin
      wr_addr[wr_n] = bus_a.mem_addr; wr_data[wr_n] = bus_a.mem_wdata; wr_cyc[wr_n] = cyc; wr_n++;
    end
    if (bus_b.mem_we === 1'b1 && wr_n < 64) begin
      wr_addr[wr_n] = bus_b.mem_addr; wr_data[wr_n] = bus_b.mem_wdata; wr_cyc[wr_n] = cyc; wr_n++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte transferred
  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    tb_valid = 1'b1;
    tb_data  = b;
    while (in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (in_ready !== 1'b1) chk("byte_timeout", {31'b0, in_ready}, 32'h1);
    @(negedge clk);
    tb_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int i = 3; i >= 0; i--) begin
      repeat ($urandom_range(0, max_gap)) @(negedge clk);
      send_byte(w[i*8 +: 8]);
    end
  endtask

  task automatic pulse_start();
    tb_start = 1'b1;
    @(negedge clk);
    tb_start = 1'b0;
  endtask

  int b0;

  initial begin
    rst_n = 1'b0; tb_start = 1'b0; tb_valid = 1'b0; tb_data = 8'h00; sel = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_flags", {26'b0, in_ready, mem_we, busy, done, err, cpu_rst_n}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic two-word load, back-to-back bytes
    pulse_start();
    chk("load_busy", {30'b0, busy, cpu_rst_n}, 32'h2);
    b0 = wr_n;
    send_word(32'h0000_0002, 0);
    send_word(32'h1234_5678, 0);
    send_word(32'h9ABC_DEF0, 0);
    chk("last_we_state", {29'b0, mem_we, in_ready, done}, 32'h4);
    @(negedge clk);
    chk("done_flags", {29'b0, done, cpu_rst_n, mem_we}, 32'h6);
    @(negedge clk);
    chk("wr_count", wr_n - b0, 2);
    chk("wr0_addr", wr_addr[b0], 32'h0);
    chk("wr0_data", wr_data[b0], 32'h1234_5678);
    chk("wr1_addr", wr_addr[b0+1], 32'h4);
    chk("wr1_data", wr_data[b0+1], 32'h9ABC_DEF0);
    chk("wr_spacing", wr_cyc[b0+1] - wr_cyc[b0], 4);

    // Restart from DONE releases nothing until reload; zero length aborts
    pulse_start();
    chk("restart_flags", {29'b0, cpu_rst_n, done, busy}, 32'h1);
    b0 = wr_n;
    send_word(32'h0000_0000, 0);
    @(negedge clk);
    chk("len0_flags", {28'b0, err, cpu_rst_n, in_ready, busy}, 32'h8);
    pulse_start();
    send_word(32'h0000_0101, 0);
    @(negedge clk);
    chk("len257_err", {30'b0, err, cpu_rst_n}, 32'h2);
    chk("err_no_write", wr_n - b0, 0);

    // Maximum length is accepted; then async reset mid-LOAD
    pulse_start();
    send_word(32'h0000_0100, 0);
    chk("len256_ok", {30'b0, busy, err}, 32'h2);
    send_byte(8'h12);
    send_byte(8'h34);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_flags", {26'b0, in_ready, mem_we, busy, done, err, cpu_rst_n}, 32'h0);
    chk("arst_addr", mem_addr, 32'h0);
    chk("arst_data", mem_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Byte alongside start in IDLE is dropped; start during LOAD is ignored
    b0 = wr_n;
    tb_start = 1'b1; tb_valid = 1'b1; tb_data = 8'hAA;
    @(negedge clk);
    tb_start = 1'b0; tb_valid = 1'b0;
    send_word(32'h0000_0002, 0);
    send_byte(8'h11);
    send_byte(8'h22);
    tb_start = 1'b1;
    send_byte(8'h33);
    tb_start = 1'b0;
    send_byte(8'h44);
    send_word(32'h5566_7788, 0);
    repeat (2) @(negedge clk);
    chk("ign_done", {30'b0, done, cpu_rst_n}, 32'h3);
    chk("ign_count", wr_n - b0, 2);
    chk("ign_wr0", wr_data[b0], 32'h1122_3344);
    chk("ign_wr1_addr", wr_addr[b0+1], 32'h4);
    chk("ign_wr1_data", wr_data[b0+1], 32'h5566_7788);

    // Second instance: BASE_ADDR 0x100 with irregular byte gaps
    sel = 1'b1;
    @(negedge clk);
    b0 = wr_n;
    pulse_start();
    send_word(32'h0000_0003, 3);
    send_word(32'hA1B2_C3D4, 3);
    send_word(32'h0BAD_F00D, 3);
    send_word(32'hCAFE_BABE, 3);
    for (int t = 0; t < 10 && done !== 1'b1; t++) @(negedge clk);
    chk("gap_done", {31'b0, done}, 32'h1);
    @(negedge clk);
    chk("gap_count", wr_n - b0, 3);
    chk("gap_a0", wr_addr[b0],   32'h100);
    chk("gap_d0", wr_data[b0],   32'hA1B2_C3D4);
    chk("gap_a1", wr_addr[b0+1], 32'h104);
    chk("gap_d1", wr_data[b0+1], 32'h0BAD_F00D);
    chk("gap_a2", wr_addr[b0+2], 32'h108);
    chk("gap_d2", wr_data[b0+2], 32'hCAFE_BABE);
    sel = 1'b0;
    @(negedge clk);

`ifdef CHECKSUM_EN
    b0 = wr_n;
    pulse_start();
    send_word(32'h0000_0002, 0);
    send_word(32'h0000_0001, 0);
    send_word(32'h0000_0002, 0);
    chk("csum_wait", {30'b0, busy, done}, 32'h2);
    send_word(32'h0000_0003, 0);
    repeat (2) @(negedge clk);
    chk("csum_ok", {29'b0, done, cpu_rst_n, err}, 32'h6);
    chk("csum_count", wr_n - b0, 2);
    pulse_start();
    send_word(32'h0000_0002, 0);
    send_word(32'h0000_0001, 0);
    send_word(32'h0000_0002, 0);
    send_word(32'h0000_0004, 0);
    repeat (2) @(negedge clk);
    chk("csum_bad", {29'b0, done, cpu_rst_n, err}, 32'h1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
